// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared constants and the round-robin search used by
// stream_mux (compile with STREAM_MUX_RR_EN for round-robin arbitration).
package stream_mux_pkg;

  localparam int DEFAULT_N     = 4;
  localparam int DEFAULT_WIDTH = 8;

  // Upper bound on channel count the round-robin search can handle
  localparam int MAX_N     = 64;
  localparam int MAX_SEL_W = 6;

  typedef struct packed {
    logic                 found;
    logic [MAX_SEL_W-1:0] idx;
  } rr_grant_t;

  // Search channels ptr+1, ptr+2, ... (wrapping modulo n) and return the
  // first one with valid high; found is low when no channel is valid.
  function automatic rr_grant_t next_rr_grant(input logic [MAX_N-1:0]     valid,
                                              input logic [MAX_SEL_W-1:0] ptr,
                                              input int                   n);
    rr_grant_t          g;
    logic [MAX_SEL_W:0] cand;
    g = '0;
    for (int k = 1; k <= MAX_N; k++) begin
      cand = {1'b0, ptr} + (MAX_SEL_W+1)'(k);
      if (int'(cand) >= n) cand = cand - (MAX_SEL_W+1)'(n);
      if (k <= n && !g.found && valid[cand[MAX_SEL_W-1:0]]) begin
        g.found = 1'b1;
        g.idx   = cand[MAX_SEL_W-1:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/stream_mux_if.sv
// stream_mux_if: N input channels plus one output stream, each with a
// valid/ready handshake. Master is the producer/consumer side, slave is the mux.
interface stream_mux_if import stream_mux_pkg::*; #(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_chan;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: round-robin grant over N requesters. The pointer remembers the
// last accepted channel and only moves when a grant is actually accepted.
// Used by stream_mux when STREAM_MUX_RR_EN is defined.
module rr_arbiter import stream_mux_pkg::*; #(
  parameter  int N     = DEFAULT_N,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             accept,
  output logic [SEL_W-1:0] grant,
  output logic             grant_ok
);

  logic [SEL_W-1:0] ptr;
  rr_grant_t        pick;
  logic             unused_idx_hi;

  // Next requester after the pointer, wrapping around
  always_comb begin
    pick = next_rr_grant(MAX_N'(req), MAX_SEL_W'(ptr), N);
  end

  assign grant         = pick.idx[SEL_W-1:0];
  assign grant_ok      = pick.found;
  assign unused_idx_hi = ^pick.idx;

  // Pointer starts at N-1 so channel 0 wins first; it holds through stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= SEL_W'(N - 1);
    end else if (accept) begin
      ptr <= grant;
    end
  end

endmodule

// File: rtl/stream_mux.sv
// stream_mux: N-channel valid/ready multiplexer with a registered output.
// Default build selects the channel with the sel port; defining
// STREAM_MUX_RR_EN replaces that with round-robin arbitration (sel unused).
module stream_mux import stream_mux_pkg::*; #(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic         clk,
  input logic         reset_n,
  stream_mux_if.slave bus
);

  localparam int SEL_W = $clog2(N);

  logic             load;
  logic             grant_ok;
  logic             xfer;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;

  // Empty or draining register can take a word; nothing is accepted in reset
  assign load = (!bus.out_valid || bus.out_ready) && reset_n;

`ifdef STREAM_MUX_RR_EN
  logic unused_sel;
  assign unused_sel = ^bus.sel;

  rr_arbiter #(.N(N)) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (bus.in_valid),
    .accept   (xfer),
    .grant    (grant),
    .grant_ok (grant_ok)
  );
`else
  assign grant    = bus.sel;
  assign grant_ok = (int'(bus.sel) < N);
`endif

  // Route the granted channel's data and raise only its ready bit
  always_comb begin
    bus.in_ready = '0;
    grant_data   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data      = bus.in_data[i*WIDTH +: WIDTH];
        bus.in_ready[i] = load && grant_ok;
      end
    end
  end

  assign xfer = |(bus.in_valid & bus.in_ready);

  // Output register: load on transfer, empty on drain, otherwise hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_chan  <= '0;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= grant_data;
      bus.out_chan  <= grant;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: scoreboard bench for stream_mux. Runs fixed-select scenarios
// in the default build and round-robin scenarios with STREAM_MUX_RR_EN.
module tb_stream_mux;
  import stream_mux_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic [1:0] chan;
  } word_t;

  logic  clk     = 1'b0;
  logic  reset_n = 1'b0;
  int    checks  = 0;
  int    fails   = 0;
  word_t exp_q[$];
  logic  m_full;
  logic [1:0] m_ptr;

  stream_mux_if #(.N(4), .WIDTH(8)) bus4 ();
  stream_mux_if #(.N(3), .WIDTH(8)) bus3 ();

  stream_mux #(.N(4), .WIDTH(8)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));
  stream_mux #(.N(3), .WIDTH(8)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] time limit");
  end

  // Expected in_ready of the 4-channel mux from the bench's own model state
  function automatic logic [3:0] model_ready();
    logic [1:0] g;
    logic       ok;
`ifdef STREAM_MUX_RR_EN
    rr_grant_t r;
    r  = next_rr_grant(64'(bus4.in_valid), 6'(m_ptr), 4);
    g  = r.idx[1:0];
    ok = r.found;
`else
    g  = bus4.sel;
    ok = 1'b1;
`endif
    if ((!m_full || bus4.out_ready) && ok) return 4'b0001 << g;
    return 4'b0000;
  endfunction

  // Advance the model across one rising edge: pop drained word, push new one
  task automatic model_advance(input logic [3:0] rdy);
    if (m_full && bus4.out_ready) begin
      void'(exp_q.pop_front());
      m_full = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (rdy[i] && bus4.in_valid[i]) begin
        exp_q.push_back('{data: bus4.in_data[i*8 +: 8], chan: 2'(i)});
        m_full = 1'b1;
        m_ptr  = 2'(i);
      end
    end
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    bus4.in_valid  = '0;
    bus4.out_ready = 1'b0;
    bus3.in_valid  = '0;
    bus3.out_ready = 1'b0;
    exp_q.delete();
    m_full = 1'b0;
    m_ptr  = 2'd3;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bus4.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    bus4.sel       = 2'd0;
    bus4.in_valid  = 4'b1111;
    bus4.out_ready = 1'b1;
    reset_n        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus4.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus4.out_valid); end
    checks++; if (bus4.out_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_out_data: got %h expected 00", bus4.out_data); end
    checks++; if (bus4.out_chan !== 2'd0) begin fails++; $display("[TB] FAIL reset_out_chan: got %0d expected 0", bus4.out_chan); end
    checks++; if (bus4.in_ready !== 4'b0000) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 0000", bus4.in_ready); end
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus4.in_ready !== 4'b0001) begin fails++; $display("[TB] FAIL first_grant: got %b expected 0001", bus4.in_ready); end
    @(negedge clk);
    checks++; if ({bus4.out_valid, bus4.out_chan, bus4.out_data} !== {1'b1, 2'd0, 8'h10}) begin
      fails++; $display("[TB] FAIL first_word: got v=%b ch=%0d d=%h expected v=1 ch=0 d=10", bus4.out_valid, bus4.out_chan, bus4.out_data);
    end
    bus4.in_data  = {8'h13, 8'h12, 8'h77, 8'h10};
    bus4.sel      = 2'd1;
    bus4.in_valid = 4'b0010;
    @(posedge clk); #2;
    checks++; if ({bus4.out_valid, bus4.out_chan, bus4.out_data} !== {1'b1, 2'd1, 8'h77}) begin
      fails++; $display("[TB] FAIL inflight_word: got v=%b ch=%0d d=%h expected v=1 ch=1 d=77", bus4.out_valid, bus4.out_chan, bus4.out_data);
    end
    reset_n = 1'b0;
    #1;
    checks++; if ({bus4.out_valid, bus4.out_chan, bus4.out_data} !== 11'd0) begin
      fails++; $display("[TB] FAIL async_reset_clear: got v=%b ch=%0d d=%h expected all 0", bus4.out_valid, bus4.out_chan, bus4.out_data);
    end
    bus4.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus4.sel      = 2'd0;
    bus4.in_valid = 4'b1111;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus4.in_ready !== 4'b0001) begin fails++; $display("[TB] FAIL regrant_after_reset: got %b expected 0001", bus4.in_ready); end
  endtask

`ifndef STREAM_MUX_RR_EN
  task automatic test_fixed_select();
    logic [3:0] rdy;
    do_reset();
    bus4.in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
    bus4.sel       = 2'd2;
    bus4.in_valid  = 4'b0100;
    bus4.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rdy = model_ready();
      checks++; if (bus4.in_ready !== rdy) begin fails++; $display("[TB] FAIL fixed_in_ready: got %b expected %b", bus4.in_ready, rdy); end
      if (m_full) begin
        checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== exp_q[0].data || bus4.out_chan !== exp_q[0].chan) begin
          fails++; $display("[TB] FAIL fixed_word: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h", bus4.out_valid, bus4.out_chan, bus4.out_data, exp_q[0].chan, exp_q[0].data);
        end
      end else begin
        checks++; if (bus4.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL fixed_empty: got v=%b expected 0", bus4.out_valid); end
      end
      if (c == 1) begin
        checks++; if ({bus4.out_valid, bus4.out_chan, bus4.out_data} !== {1'b1, 2'd2, 8'hA5}) begin
          fails++; $display("[TB] FAIL fixed_a5: got v=%b ch=%0d d=%h expected v=1 ch=2 d=a5", bus4.out_valid, bus4.out_chan, bus4.out_data);
        end
      end
      model_advance(rdy);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] rdy;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      bus4.in_data   = {8'h00, 8'h5A, 8'h00, 8'h00};
      bus4.out_ready = (c >= 5);
      bus4.in_valid  = (c < 6) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      rdy = model_ready();
      checks++; if (bus4.in_ready !== rdy) begin fails++; $display("[TB] FAIL bp_in_ready: got %b expected %b", bus4.in_ready, rdy); end
      if (m_full) begin
        checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== exp_q[0].data || bus4.out_chan !== exp_q[0].chan) begin
          fails++; $display("[TB] FAIL bp_word: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h", bus4.out_valid, bus4.out_chan, bus4.out_data, exp_q[0].chan, exp_q[0].data);
        end
      end else begin
        checks++; if (bus4.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_empty: got v=%b expected 0", bus4.out_valid); end
      end
      if (c < 5) begin
        checks++; if (bus4.out_data !== 8'hA5 || bus4.in_ready !== 4'b0000) begin
          fails++; $display("[TB] FAIL bp_hold: got d=%h rdy=%b expected d=a5 rdy=0000", bus4.out_data, bus4.in_ready);
        end
      end
      if (c == 5) begin
        checks++; if (bus4.in_ready !== 4'b0100) begin fails++; $display("[TB] FAIL bp_release: got %b expected 0100", bus4.in_ready); end
      end
      if (c == 6) begin
        checks++; if (bus4.out_data !== 8'h5A) begin fails++; $display("[TB] FAIL bp_next_word: got %h expected 5a", bus4.out_data); end
      end
      if (c == 7) begin
        checks++; if (bus4.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_drain: got %b expected 0", bus4.out_valid); end
      end
      model_advance(rdy);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    bus3.in_data   = {8'h33, 8'h22, 8'h11};
    bus3.in_valid  = 3'b111;
    bus3.sel       = 2'd0;
    bus3.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus3.in_ready !== 3'b001) begin fails++; $display("[TB] FAIL oor_in_range: got %b expected 001", bus3.in_ready); end
    @(posedge clk); #1 bus3.sel = 2'd3;
    @(negedge clk);
    checks++; if (bus3.in_ready !== 3'b000) begin fails++; $display("[TB] FAIL oor_in_ready: got %b expected 000", bus3.in_ready); end
    checks++; if (bus3.out_valid !== 1'b1 || bus3.out_data !== 8'h11) begin
      fails++; $display("[TB] FAIL oor_last_word: got v=%b d=%h expected v=1 d=11", bus3.out_valid, bus3.out_data);
    end
    @(negedge clk);
    checks++; if (bus3.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL oor_drain: got %b expected 0", bus3.out_valid); end
    bus3.in_valid = 3'b000;
  endtask
`else
  task automatic test_rr_fairness();
    logic [3:0] rdy;
    do_reset();
    bus4.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    bus4.in_valid  = 4'b1111;
    bus4.out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      rdy = model_ready();
      checks++; if (bus4.in_ready !== (4'b0001 << (c % 4))) begin
        fails++; $display("[TB] FAIL rr_grant_order: cycle %0d got %b expected %b", c, bus4.in_ready, 4'b0001 << (c % 4));
      end
      if (c >= 1) begin
        checks++; if ({bus4.out_valid, bus4.out_chan, bus4.out_data} !== {1'b1, 2'((c - 1) % 4), 8'(8'h10 + (c - 1) % 4)}) begin
          fails++; $display("[TB] FAIL rr_out_seq: cycle %0d got v=%b ch=%0d d=%h expected ch=%0d", c, bus4.out_valid, bus4.out_chan, bus4.out_data, (c - 1) % 4);
        end
      end
      model_advance(rdy);
    end
  endtask

  task automatic test_rr_stall_skip();
    logic [3:0] rdy;
    logic       ordy_tab [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] rdy_tab  [6] = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b1000};
    do_reset();
    bus4.in_data  = {8'h43, 8'h42, 8'h41, 8'h40};
    bus4.in_valid = 4'b1010;
    for (int c = 0; c < 6; c++) begin
      bus4.out_ready = ordy_tab[c];
      @(negedge clk);
      rdy = model_ready();
      checks++; if (bus4.in_ready !== rdy_tab[c]) begin
        fails++; $display("[TB] FAIL rr_skip_grant: cycle %0d got %b expected %b", c, bus4.in_ready, rdy_tab[c]);
      end
      if (m_full) begin
        checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== exp_q[0].data || bus4.out_chan !== exp_q[0].chan) begin
          fails++; $display("[TB] FAIL rr_skip_word: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h", bus4.out_valid, bus4.out_chan, bus4.out_data, exp_q[0].chan, exp_q[0].data);
        end
      end
      model_advance(rdy);
      @(posedge clk); #1;
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [3:0] rdy;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      bus4.in_data   = 32'($urandom);
      bus4.in_valid  = 4'($urandom);
      bus4.sel       = 2'($urandom);
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      rdy = model_ready();
      checks++; if (bus4.in_ready !== rdy) begin fails++; $display("[TB] FAIL b2b_in_ready: cycle %0d got %b expected %b", c, bus4.in_ready, rdy); end
      if (m_full) begin
        checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== exp_q[0].data || bus4.out_chan !== exp_q[0].chan) begin
          fails++; $display("[TB] FAIL b2b_word: cycle %0d got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h", c, bus4.out_valid, bus4.out_chan, bus4.out_data, exp_q[0].chan, exp_q[0].data);
        end
      end else begin
        checks++; if (bus4.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_empty: cycle %0d got v=%b expected 0", c, bus4.out_valid); end
      end
      model_advance(rdy);
      @(posedge clk); #1;
    end
  endtask

  // Scenario sequence
  initial begin
    bus4.in_data   = '0;
    bus4.in_valid  = '0;
    bus4.sel       = '0;
    bus4.out_ready = 1'b0;
    bus3.in_data   = '0;
    bus3.in_valid  = '0;
    bus3.sel       = '0;
    bus3.out_ready = 1'b0;
    $display("[TB] stream_mux bench start");
    test_reset();
`ifdef STREAM_MUX_RR_EN
    test_rr_fairness();
    test_rr_stall_skip();
`else
    test_fixed_select();
    test_backpressure();
    test_out_of_range();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
